// File: rtl/reg_ctrl.sv
// reg_ctrl: command sequencer for a 16 x 8 register file (two combinational
// read ports, one synchronous write port). Accepts one command at a time over
// valid/ready, reads operands, computes the result, writes it back and pulses
// done.
//
// Optional feature macro: REG_CTRL_CLEAR_EN
//   defined   : op 111 clears every register, one write per cycle
//   undefined : op 111 behaves as NOP and no clear counter is built
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | cmd_ready=1, waiting for a handshake
// S_EXEC  | read addresses driven from latched fields, ALU result captured
// S_WRITE | write-back of the captured result, done pulse
// S_CLR   | sweep of all registers with zero (REG_CTRL_CLEAR_EN only)

module reg_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [ADDR_W-1:0] cmd_src0,
    input  logic [ADDR_W-1:0] cmd_src1,
    input  logic [DATA_W-1:0] cmd_imm,
    output logic [ADDR_W-1:0] rf_src0,
    output logic [ADDR_W-1:0] rf_src1,
    input  logic [DATA_W-1:0] rf_data0,
    input  logic [DATA_W-1:0] rf_data1,
    output logic [ADDR_W-1:0] rf_dst,
    output logic [DATA_W-1:0] rf_data,
    output logic              rf_we,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              zero,
    output logic              carry
);

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_LOADI = 3'b001;
    localparam logic [2:0] OP_MOV   = 3'b010;
    localparam logic [2:0] OP_ADD   = 3'b011;
    localparam logic [2:0] OP_SUB   = 3'b100;
    localparam logic [2:0] OP_AND   = 3'b101;
    localparam logic [2:0] OP_OR    = 3'b110;
`ifdef REG_CTRL_CLEAR_EN
    localparam logic [2:0] OP_CLEAR = 3'b111;
    localparam logic [ADDR_W-1:0] LAST_ADDR    = '1;
    localparam logic [ADDR_W-1:0] LAST_ADDR_M1 = LAST_ADDR - 1'b1;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_WRITE = 2'd2,
        S_CLR   = 2'd3
    } state_t;

    state_t            state;
    logic [2:0]        op_q;
    logic [ADDR_W-1:0] dst_q;
    logic [ADDR_W-1:0] src0_q;
    logic [ADDR_W-1:0] src1_q;
    logic [DATA_W-1:0] imm_q;
    logic              ready_q;
    logic              we_q;
    logic              done_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DATA_W-1:0] wr_data_q;
    logic [DATA_W-1:0] result_q;
    logic              zero_q;
    logic              carry_q;

    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   diff;
    logic [DATA_W-1:0] alu_res;
    logic              alu_carry;
    logic              alu_writes;

    // ALU on the live register-file read data; non-writing ops hold the flags
    always_comb begin
        sum        = {1'b0, rf_data0} + {1'b0, rf_data1};
        diff       = {1'b0, rf_data0} - {1'b0, rf_data1};
        alu_res    = result_q;
        alu_carry  = carry_q;
        alu_writes = 1'b0;
        case (op_q)
            OP_LOADI: begin alu_res = imm_q;              alu_carry = 1'b0;         alu_writes = 1'b1; end
            OP_MOV:   begin alu_res = rf_data0;           alu_carry = 1'b0;         alu_writes = 1'b1; end
            OP_ADD:   begin alu_res = sum[DATA_W-1:0];    alu_carry = sum[DATA_W];  alu_writes = 1'b1; end
            OP_SUB:   begin alu_res = diff[DATA_W-1:0];   alu_carry = diff[DATA_W]; alu_writes = 1'b1; end
            OP_AND:   begin alu_res = rf_data0 & rf_data1; alu_carry = 1'b0;        alu_writes = 1'b1; end
            OP_OR:    begin alu_res = rf_data0 | rf_data1; alu_carry = 1'b0;        alu_writes = 1'b1; end
            default:  begin alu_writes = 1'b0; end
        endcase
    end

    // Sequencer FSM with registered handshake, write-port and flag outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            op_q      <= OP_NOP;
            dst_q     <= '0;
            src0_q    <= '0;
            src1_q    <= '0;
            imm_q     <= '0;
            ready_q   <= 1'b1;
            we_q      <= 1'b0;
            done_q    <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    we_q   <= 1'b0;
                    done_q <= 1'b0;
                    if (cmd_valid && ready_q) begin
                        op_q    <= cmd_op;
                        dst_q   <= cmd_dst;
                        src0_q  <= cmd_src0;
                        src1_q  <= cmd_src1;
                        imm_q   <= cmd_imm;
                        ready_q <= 1'b0;
`ifdef REG_CTRL_CLEAR_EN
                        if (cmd_op == OP_CLEAR) begin
                            state     <= S_CLR;
                            we_q      <= 1'b1;
                            wr_addr_q <= '0;
                            wr_data_q <= '0;
                            result_q  <= '0;
                            zero_q    <= 1'b1;
                            carry_q   <= 1'b0;
                        end else begin
                            state <= S_EXEC;
                        end
`else
                        state <= S_EXEC;
`endif
                    end
                end
                S_EXEC: begin
                    state     <= S_WRITE;
                    result_q  <= alu_res;
                    zero_q    <= alu_writes ? (alu_res == '0) : zero_q;
                    carry_q   <= alu_carry;
                    wr_addr_q <= dst_q;
                    wr_data_q <= alu_res;
                    we_q      <= alu_writes;
                    done_q    <= 1'b1;
                end
                S_WRITE: begin
                    state   <= S_IDLE;
                    we_q    <= 1'b0;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                S_CLR: begin
`ifdef REG_CTRL_CLEAR_EN
                    // done_q marks the final address, so leaving after it ends the sweep
                    if (done_q) begin
                        state   <= S_IDLE;
                        we_q    <= 1'b0;
                        done_q  <= 1'b0;
                        ready_q <= 1'b1;
                    end else begin
                        wr_addr_q <= wr_addr_q + 1'b1;
                        done_q    <= (wr_addr_q == LAST_ADDR_M1);
                    end
`else
                    state   <= S_IDLE;
                    we_q    <= 1'b0;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
`endif
                end
                default: begin
                    state   <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Reset must suppress a write or done already registered for this cycle
    assign rf_we     = we_q & ~rst;
    assign done      = done_q & ~rst;
    assign cmd_ready = ready_q;
    assign rf_src0   = src0_q;
    assign rf_src1   = src1_q;
    assign rf_dst    = wr_addr_q;
    assign rf_data   = wr_data_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign carry     = carry_q;

endmodule

// File: tb/tb_reg_ctrl.sv
// Self-checking bench for reg_ctrl: a behavioural register file drives the
// read ports, and a reference model computes expected writes and flags.

module tb_reg_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'd0;
    logic [3:0] cmd_dst = 4'd0;
    logic [3:0] cmd_src0 = 4'd0;
    logic [3:0] cmd_src1 = 4'd0;
    logic [7:0] cmd_imm = 8'd0;
    logic [3:0] rf_src0, rf_src1, rf_dst;
    logic [7:0] rf_data0, rf_data1, rf_data;
    logic       rf_we, done;
    logic [7:0] result;
    logic       zero, carry;
    logic       rf_init = 1'b1;

    logic [7:0] rf_mem [16];

    int pass_cnt = 0;
    int total = 0;

    bit [7:0] model_rf [16];
    bit [7:0] m_result = 8'd0;
    bit       m_zero = 1'b0;
    bit       m_carry = 1'b0;

    bit       obs_timeout;
    int       obs_done_n;
    bit       obs_ready_after;
    int       obs_n [$];
    bit [3:0] obs_dst [$];
    bit [7:0] obs_data [$];

    reg_ctrl #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_src0(cmd_src0),
        .cmd_src1(cmd_src1), .cmd_imm(cmd_imm),
        .rf_src0(rf_src0), .rf_src1(rf_src1),
        .rf_data0(rf_data0), .rf_data1(rf_data1),
        .rf_dst(rf_dst), .rf_data(rf_data), .rf_we(rf_we),
        .done(done), .result(result), .zero(zero), .carry(carry)
    );

    always #5 clk = ~clk;

    assign rf_data0 = rf_mem[rf_src0];
    assign rf_data1 = rf_mem[rf_src1];

    always @(posedge clk) begin
        if (rf_init) begin
            for (int i = 0; i < 16; i++) rf_mem[i] <= 8'd0;
        end else if (rf_we) begin
            rf_mem[rf_dst] <= rf_data;
        end
    end

    // Reference model: architectural effect of one command
    function automatic void model_exec(input bit [2:0] op, input bit [3:0] dst,
                                       input bit [3:0] s0, input bit [3:0] s1,
                                       input bit [7:0] imm,
                                       output bit exp_we, output bit [7:0] exp_data);
        int a, b, r;
        bit c, wr;
        a = model_rf[s0];
        b = model_rf[s1];
        r = 0; c = 1'b0; wr = 1'b1;
        case (op)
            3'd1: r = imm;
            3'd2: r = a;
            3'd3: begin r = (a + b) % 256; c = (a + b) > 255; end
            3'd4: begin r = (a - b + 256) % 256; c = (a < b); end
            3'd5: r = a & b;
            3'd6: r = a | b;
            3'd7: begin
                wr = 1'b0;
`ifdef REG_CTRL_CLEAR_EN
                for (int i = 0; i < 16; i++) model_rf[i] = 8'd0;
                m_result = 8'd0; m_zero = 1'b1; m_carry = 1'b0;
`endif
            end
            default: wr = 1'b0;
        endcase
        if (wr) begin
            m_result = r[7:0];
            m_zero   = (r == 0);
            m_carry  = c;
            model_rf[dst] = r[7:0];
        end
        exp_we   = wr;
        exp_data = wr ? r[7:0] : m_result;
    endfunction

    // Drives one command and records what the DUT does until done
    task automatic run_cmd(input bit [2:0] op, input bit [3:0] dst, input bit [3:0] s0,
                           input bit [3:0] s1, input bit [7:0] imm);
        int n;
        obs_timeout = 1'b0; obs_done_n = 0; obs_ready_after = 1'b0;
        obs_n.delete(); obs_dst.delete(); obs_data.delete();
        @(negedge clk);
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        if (!cmd_ready) begin obs_timeout = 1'b1; return; end
        cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst; cmd_src0 = s0; cmd_src1 = s1; cmd_imm = imm;
        @(posedge clk);
        for (n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (rf_we) begin obs_n.push_back(n); obs_dst.push_back(rf_dst); obs_data.push_back(rf_data); end
            if (n == 1) begin
                cmd_valid = 1'b0;
                cmd_op = 3'($urandom); cmd_dst = 4'($urandom); cmd_src0 = 4'($urandom);
                cmd_src1 = 4'($urandom); cmd_imm = 8'($urandom);
            end
            if (done) begin obs_done_n = n; break; end
        end
        if (obs_done_n == 0) obs_timeout = 1'b1;
        else begin @(negedge clk); obs_ready_after = cmd_ready; end
    endtask

    task automatic test_reset;
        int dcnt;
        rst = 1'b1; rf_init = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (cmd_ready !== 1'b1) $display("FAIL rst_ready got %0b exp 1", cmd_ready); else pass_cnt++;
        total++; if (rf_we !== 1'b0) $display("FAIL rst_we got %0b exp 0", rf_we); else pass_cnt++;
        total++; if (done !== 1'b0) $display("FAIL rst_done got %0b exp 0", done); else pass_cnt++;
        total++; if (result !== 8'h00) $display("FAIL rst_result got %0h exp 0", result); else pass_cnt++;
        total++; if (zero !== 1'b0) $display("FAIL rst_zero got %0b exp 0", zero); else pass_cnt++;
        total++; if (carry !== 1'b0) $display("FAIL rst_carry got %0b exp 0", carry); else pass_cnt++;
        total++; if (rf_src0 !== 4'd0 || rf_src1 !== 4'd0) $display("FAIL rst_src got %0d/%0d exp 0/0", rf_src0, rf_src1); else pass_cnt++;
        total++; if (rf_dst !== 4'd0) $display("FAIL rst_dst got %0d exp 0", rf_dst); else pass_cnt++;
        total++; if (rf_data !== 8'd0) $display("FAIL rst_wdata got %0h exp 0", rf_data); else pass_cnt++;
        rst = 1'b0; rf_init = 1'b0;
        @(negedge clk);
        // handshake presented while reset is high must be dropped
        rst = 1'b1; cmd_valid = 1'b1; cmd_op = 3'd1; cmd_dst = 4'd5; cmd_imm = 8'h99;
        @(negedge clk);
        rst = 1'b0; cmd_valid = 1'b0;
        total++; if (cmd_ready !== 1'b1) $display("FAIL rst_prio_ready got %0b exp 1", cmd_ready); else pass_cnt++;
        dcnt = 0;
        repeat (4) begin @(negedge clk); if (done) dcnt++; end
        total++; if (dcnt !== 0) $display("FAIL rst_prio_done got %0d pulses exp 0", dcnt); else pass_cnt++;
        total++; if (rf_mem[5] !== model_rf[5]) $display("FAIL rst_prio_r5 got %0h exp %0h", rf_mem[5], model_rf[5]); else pass_cnt++;
    endtask

    task automatic test_loadi;
        bit ew; bit [7:0] ed;
        run_cmd(3'd1, 4'd3, 4'd0, 4'd0, 8'h5A);
        model_exec(3'd1, 4'd3, 4'd0, 4'd0, 8'h5A, ew, ed);
        total++; if (obs_timeout !== 1'b0) $display("FAIL loadi_timeout got 1 exp 0"); else pass_cnt++;
        total++; if (obs_done_n !== 2) $display("FAIL loadi_done_cycle got T+%0d exp T+2", obs_done_n); else pass_cnt++;
        total++; if (obs_n.size() !== 1) $display("FAIL loadi_we_count got %0d exp 1", obs_n.size()); else pass_cnt++;
        if (obs_n.size() > 0) begin
            total++; if (obs_n[0] !== 2) $display("FAIL loadi_we_cycle got T+%0d exp T+2", obs_n[0]); else pass_cnt++;
            total++; if (obs_dst[0] !== 4'd3) $display("FAIL loadi_dst got %0d exp 3", obs_dst[0]); else pass_cnt++;
            total++; if (obs_data[0] !== 8'h5A) $display("FAIL loadi_data got %0h exp 5a", obs_data[0]); else pass_cnt++;
        end
        total++; if (obs_ready_after !== 1'b1) $display("FAIL loadi_ready_t3 got %0b exp 1", obs_ready_after); else pass_cnt++;
        total++; if (zero !== 1'b0) $display("FAIL loadi_zero got %0b exp 0", zero); else pass_cnt++;
        total++; if (rf_mem[3] !== 8'h5A) $display("FAIL loadi_r3 got %0h exp 5a", rf_mem[3]); else pass_cnt++;
    endtask

    task automatic test_alu_directed;
        bit [2:0] op [14]  = '{3'd1, 3'd1, 3'd3, 3'd2, 3'd1, 3'd1, 3'd4, 3'd1, 3'd1, 3'd4, 3'd1, 3'd1, 3'd5, 3'd6};
        bit [3:0] dst [14] = '{4'd1, 4'd2, 4'd4, 4'd7, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
        bit [3:0] s0 [14]  = '{4'd0, 4'd0, 4'd1, 4'd4, 4'd0, 4'd0, 4'd5, 4'd0, 4'd0, 4'd9, 4'd0, 4'd0, 4'd12, 4'd12};
        bit [3:0] s1 [14]  = '{4'd0, 4'd0, 4'd2, 4'd0, 4'd0, 4'd0, 4'd6, 4'd0, 4'd0, 4'd10, 4'd0, 4'd0, 4'd13, 4'd13};
        bit [7:0] imm [14] = '{8'hF0, 8'h20, 8'h00, 8'h00, 8'h10, 8'h10, 8'h00, 8'h01, 8'h02, 8'h00, 8'hF0, 8'h0F, 8'h00, 8'h00};
        bit ew; bit [7:0] ed;
        for (int i = 0; i < 14; i++) begin
            run_cmd(op[i], dst[i], s0[i], s1[i], imm[i]);
            model_exec(op[i], dst[i], s0[i], s1[i], imm[i], ew, ed);
            total++; if (obs_done_n !== 2) $display("FAIL dir%0d_done_cycle got T+%0d exp T+2", i, obs_done_n); else pass_cnt++;
            total++; if (obs_dst.size() !== 1 || obs_dst[0] !== dst[i] || obs_data[0] !== ed)
                $display("FAIL dir%0d_write got n=%0d dst=%0d data=%0h exp dst=%0d data=%0h", i, obs_dst.size(),
                         obs_dst.size() > 0 ? obs_dst[0] : 4'd0, obs_data.size() > 0 ? obs_data[0] : 8'd0, dst[i], ed);
            else pass_cnt++;
            total++; if ({result, zero, carry} !== {m_result, m_zero, m_carry})
                $display("FAIL dir%0d_flags got %0h/z%0b/c%0b exp %0h/z%0b/c%0b", i, result, zero, carry, m_result, m_zero, m_carry);
            else pass_cnt++;
        end
        // spot checks of well-known values
        total++; if (rf_mem[4] !== 8'h10 || rf_mem[7] !== 8'h10) $display("FAIL dir_add_mov got %0h/%0h exp 10/10", rf_mem[4], rf_mem[7]); else pass_cnt++;
        total++; if (rf_mem[8] !== 8'h00 || rf_mem[11] !== 8'hFF) $display("FAIL dir_sub got %0h/%0h exp 00/ff", rf_mem[8], rf_mem[11]); else pass_cnt++;
    endtask

    task automatic test_random;
        bit [2:0] op; bit [3:0] d, a, b; bit [7:0] im;
        bit ew; bit [7:0] ed;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 6)); d = 4'($urandom); a = 4'($urandom); b = 4'($urandom); im = 8'($urandom);
            run_cmd(op, d, a, b, im);
            model_exec(op, d, a, b, im, ew, ed);
            total++; if (obs_done_n !== 2) $display("FAIL rnd%0d_done_cycle got T+%0d exp T+2", i, obs_done_n); else pass_cnt++;
            total++; if (obs_dst.size() !== int'(ew)) $display("FAIL rnd%0d_we_count got %0d exp %0d", i, obs_dst.size(), ew); else pass_cnt++;
            if (ew && obs_dst.size() > 0) begin
                total++; if (obs_dst[0] !== d || obs_data[0] !== ed)
                    $display("FAIL rnd%0d_write got dst=%0d data=%0h exp dst=%0d data=%0h", i, obs_dst[0], obs_data[0], d, ed);
                else pass_cnt++;
            end
            total++; if ({result, zero, carry} !== {m_result, m_zero, m_carry})
                $display("FAIL rnd%0d_flags op=%0d got %0h/z%0b/c%0b exp %0h/z%0b/c%0b", i, op, result, zero, carry, m_result, m_zero, m_carry);
            else pass_cnt++;
            total++; if (obs_ready_after !== 1'b1) $display("FAIL rnd%0d_ready_t3 got %0b exp 1", i, obs_ready_after); else pass_cnt++;
        end
        for (int r = 0; r < 16; r++) begin
            total++; if (rf_mem[r] !== model_rf[r]) $display("FAIL rnd_rf%0d got %0h exp %0h", r, rf_mem[r], model_rf[r]); else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back;
        bit [3:0] exp_dst [3];
        bit [7:0] exp_data [3];
        bit ew, exp_rdy, exp_dn;
        bit [7:0] ed;
        int n, k;
        @(negedge clk);
        n = 0;
        while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
        total++; if (cmd_ready !== 1'b1) $display("FAIL b2b_start_ready got %0b exp 1", cmd_ready); else pass_cnt++;
        k = 0;
        for (int c = 0; c < 11; c++) begin
            exp_rdy = (c % 3 == 0);
            exp_dn  = (c == 2 || c == 5 || c == 8);
            if (c <= 9) begin
                total++; if (cmd_ready !== exp_rdy) $display("FAIL b2b_ready_c%0d got %0b exp %0b", c, cmd_ready, exp_rdy); else pass_cnt++;
            end
            total++; if (done !== exp_dn) $display("FAIL b2b_done_c%0d got %0b exp %0b", c, done, exp_dn); else pass_cnt++;
            total++; if (rf_we !== exp_dn) $display("FAIL b2b_we_c%0d got %0b exp %0b", c, rf_we, exp_dn); else pass_cnt++;
            if (exp_dn) begin
                total++; if (rf_dst !== exp_dst[c/3] || rf_data !== exp_data[c/3])
                    $display("FAIL b2b_write_c%0d got dst=%0d data=%0h exp dst=%0d data=%0h", c, rf_dst, rf_data, exp_dst[c/3], exp_data[c/3]);
                else pass_cnt++;
            end
            if (c < 9) begin
                cmd_valid = 1'b1;
                cmd_op = 3'($urandom_range(1, 6)); cmd_dst = 4'($urandom); cmd_src0 = 4'($urandom);
                cmd_src1 = 4'($urandom); cmd_imm = 8'($urandom);
                if (c % 3 == 0) begin
                    model_exec(cmd_op, cmd_dst, cmd_src0, cmd_src1, cmd_imm, ew, ed);
                    exp_dst[k] = cmd_dst; exp_data[k] = ed; k++;
                end
            end else begin
                cmd_valid = 1'b0;
            end
            @(negedge clk);
        end
        total++; if ({result, zero, carry} !== {m_result, m_zero, m_carry})
            $display("FAIL b2b_flags got %0h/z%0b/c%0b exp %0h/z%0b/c%0b", result, zero, carry, m_result, m_zero, m_carry);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        bit ew; bit [7:0] ed;
        int dcnt;
        run_cmd(3'd1, 4'd1, 4'd0, 4'd0, 8'h33); model_exec(3'd1, 4'd1, 4'd0, 4'd0, 8'h33, ew, ed);
        run_cmd(3'd1, 4'd2, 4'd0, 4'd0, 8'h44); model_exec(3'd1, 4'd2, 4'd0, 4'd0, 8'h44, ew, ed);
        // reset during EXEC of an ADD
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd3; cmd_dst = 4'd9; cmd_src0 = 4'd1; cmd_src1 = 4'd2;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0; rst = 1'b1;
        total++; if (rf_we !== 1'b0) $display("FAIL rexec_we_in_rst got %0b exp 0", rf_we); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        m_result = 8'd0; m_zero = 1'b0; m_carry = 1'b0;
        total++; if ({rf_we, done, cmd_ready} !== 3'b001) $display("FAIL rexec_ctrl got we%0b/done%0b/rdy%0b exp we0/done0/rdy1", rf_we, done, cmd_ready); else pass_cnt++;
        total++; if ({result, zero, carry} !== 10'd0) $display("FAIL rexec_flags got %0h/z%0b/c%0b exp 0/z0/c0", result, zero, carry); else pass_cnt++;
        total++; if ({rf_dst, rf_data, rf_src0, rf_src1} !== 20'd0) $display("FAIL rexec_ports got dst=%0d data=%0h s0=%0d s1=%0d exp zeros", rf_dst, rf_data, rf_src0, rf_src1); else pass_cnt++;
        dcnt = 0;
        repeat (4) begin @(negedge clk); if (done || rf_we) dcnt++; end
        total++; if (dcnt !== 0) $display("FAIL rexec_late_activity got %0d exp 0", dcnt); else pass_cnt++;
        total++; if (rf_mem[9] !== model_rf[9]) $display("FAIL rexec_r9 got %0h exp %0h", rf_mem[9], model_rf[9]); else pass_cnt++;
        // reset in the WRITE cycle itself must block the write
        cmd_valid = 1'b1; cmd_op = 3'd1; cmd_dst = 4'd10; cmd_imm = 8'h77;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (rf_we !== 1'b0 || done !== 1'b0) $display("FAIL rwrite_gate got we%0b/done%0b exp we0/done0", rf_we, done); else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        total++; if (rf_mem[10] !== model_rf[10]) $display("FAIL rwrite_r10 got %0h exp %0h", rf_mem[10], model_rf[10]); else pass_cnt++;
    endtask

    task automatic test_op7;
        bit ew; bit [7:0] ed;
        int bad;
        run_cmd(3'd1, 4'd6, 4'd0, 4'd0, 8'hA5); model_exec(3'd1, 4'd6, 4'd0, 4'd0, 8'hA5, ew, ed);
        run_cmd(3'd7, 4'd6, 4'd0, 4'd0, 8'h00);
        model_exec(3'd7, 4'd6, 4'd0, 4'd0, 8'h00, ew, ed);
        total++; if (obs_timeout !== 1'b0) $display("FAIL op7_timeout got 1 exp 0"); else pass_cnt++;
`ifdef REG_CTRL_CLEAR_EN
        total++; if (obs_done_n !== 16) $display("FAIL op7_done_cycle got T+%0d exp T+16", obs_done_n); else pass_cnt++;
        total++; if (obs_dst.size() !== 16) $display("FAIL op7_we_count got %0d exp 16", obs_dst.size()); else pass_cnt++;
        bad = 0;
        for (int i = 0; i < obs_dst.size(); i++)
            if (obs_n[i] !== i + 1 || obs_dst[i] !== 4'(i) || obs_data[i] !== 8'd0) bad++;
        total++; if (bad !== 0) $display("FAIL op7_sweep got %0d bad write cycles exp 0", bad); else pass_cnt++;
`else
        total++; if (obs_done_n !== 2) $display("FAIL op7_done_cycle got T+%0d exp T+2", obs_done_n); else pass_cnt++;
        total++; if (obs_dst.size() !== 0) $display("FAIL op7_we_count got %0d exp 0", obs_dst.size()); else pass_cnt++;
`endif
        total++; if ({result, zero, carry} !== {m_result, m_zero, m_carry})
            $display("FAIL op7_flags got %0h/z%0b/c%0b exp %0h/z%0b/c%0b", result, zero, carry, m_result, m_zero, m_carry);
        else pass_cnt++;
        bad = 0;
        for (int r = 0; r < 16; r++) if (rf_mem[r] !== model_rf[r]) bad++;
        total++; if (bad !== 0) $display("FAIL op7_rf got %0d differing registers exp 0", bad); else pass_cnt++;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) model_rf[i] = 8'd0;
        test_reset();
        test_loadi();
        test_alu_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        test_op7();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp completion (%0d/%0d so far)", pass_cnt, total);
        $fatal(1);
    end

endmodule

// File: doc/reg_ctrl.md
# reg_ctrl

Command sequencer for the 16-entry x 8-bit register file: two combinational read ports, one synchronous write port. Accepts one register-transfer/ALU command at a time over a valid/ready handshake. Drives the read addresses, captures the operands and computes the result. Writes the result back through the write port and pulses `done`. It is the sole master of the register file's address, data and write-enable inputs.

## Interface
- `DATA_W`, 8, register/data width
- `ADDR_W`, 4, register address width (2**ADDR_W registers)

- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  controller can accept a command
- `cmd_op`  in  3  opcode
- `cmd_dst`  in  ADDR_W  destination register
- `cmd_src0`  in  ADDR_W  operand A register
- `cmd_src1`  in  ADDR_W  operand B register
- `cmd_imm`  in  DATA_W  immediate for LOADI
- `rf_src0`  out  ADDR_W  register-file read address A
- `rf_src1`  out  ADDR_W  register-file read address B
- `rf_data0`  in  DATA_W  register-file read data A (combinational)
- `rf_data1`  in  DATA_W  register-file read data B (combinational)
- `rf_dst`  out  ADDR_W  register-file write address
- `rf_data`  out  DATA_W  register-file write data
- `rf_we`  out  1  register-file write enable
- `done`  out  1  one-cycle completion pulse
- `result`  out  DATA_W  last computed result
- `zero`  out  1  result == 0
- `carry`  out  1  ADD carry-out / SUB borrow

## Operation
- Opcodes:
  - 000 NOP: no write
  - 001 LOADI: dst <= imm
  - 010 MOV: dst <= R[src0]
  - 011 ADD: dst <= R[src0]+R[src1]
  - 100 SUB: dst <= R[src0]-R[src1]
  - 101 AND
  - 110 OR
  - 111 CLEAR (see Configuration)
- FSM states:
  - IDLE: `cmd_ready`=1. Handshake `cmd_valid && cmd_ready` latches op/dst/src0/src1/imm, then -> EXEC.
  - EXEC: `rf_src0`/`rf_src1` driven from latched fields. Operands from `rf_data0`/`rf_data1` feed the ALU. `result`, `zero`, `carry` register at end of cycle. -> WRITE.
  - WRITE: `rf_dst`=latched dst, `rf_data`=`result`, `rf_we`=1 unless NOP, `done`=1. -> IDLE.
- Latched command is immune to input changes after acceptance. `cmd_*` ignored while `cmd_ready`=0.
- Arithmetic: DATA_W wide, wraps modulo 2**DATA_W.
  - `carry`: carry-out for ADD; 1 when R[src0] < R[src1] for SUB; 0 for all other ops.
  - `zero` reflects the new `result` for every op except NOP.
  - NOP leaves `result`/`zero`/`carry` unchanged.
- Outside WRITE/CLR: `rf_we`=0, `done`=0.

## Timing
- Accept at cycle T. EXEC at T+1. WRITE and `done` at T+2; the register file updates at the end of T+2. `cmd_ready`=1 again at T+3.
- Throughput: one command per 3 cycles; back-to-back `cmd_valid` is accepted at T, T+3, T+6...
- No read-after-write hazard: the next command's EXEC is at T+4 or later, after the write is committed.
- Reset values (cycle after `rst`=1): state IDLE, `cmd_ready`=1, `rf_we`=0, `done`=0, `result`=0, `zero`=0, `carry`=0, `rf_src0`/`rf_src1`/`rf_dst`/`rf_data`=0.
- Reset mid-operation (EXEC, WRITE or CLR): the command is abandoned. No `rf_we` in any cycle where `rst`=1. No `done`.
- `rst` has priority over a simultaneous handshake; the command is not accepted.

## Configuration
- Macro: `REG_CTRL_CLEAR_EN`.
- With the macro defined:
  - Op 111 enters state CLR after acceptance, skipping EXEC/WRITE.
  - CLR drives `rf_we`=1, `rf_data`=0 and `rf_dst`=counter, for 2**ADDR_W consecutive cycles with the counter stepping 0..2**ADDR_W-1.
  - `done`=1 on the last write cycle, then -> IDLE.
  - `result`=0, `zero`=1, `carry`=0.
- Without the macro: op 111 behaves exactly as NOP (3-cycle, no write, `done` at T+2). No counter logic is synthesized.

## Test plan
- Reset, then LOADI dst=3 imm=0x5A. Expected: at T+2 `rf_we`=1, `rf_dst`=3, `rf_data`=0x5A, `done`=1; `cmd_ready`=1 at T+3; `zero`=0.
- Preload R1=0xF0, R2=0x20; ADD src0=1 src1=2 dst=4. Expected: write R4=0x10, `carry`=1, `zero`=0. Then MOV src0=4 dst=7 writes R7=0x10.
- SUB 0x10-0x10. Expected: `result`=0x00, `zero`=1, `carry`=0. Then SUB 0x01-0x02. Expected: `result`=0xFF, `carry`=1. AND 0xF0&0x0F gives 0x00 with `carry`=0.
- Hold `cmd_valid`=1 with changing fields for 9 cycles. Expected: exactly 3 accepts, at T, T+3, T+6, each executing the fields present at its accept cycle.
- Assert `rst` during the EXEC of an ADD. Expected: no `rf_we`, no `done`; next cycle all outputs at reset values and `cmd_ready`=1.
- Op 111, with `REG_CTRL_CLEAR_EN`. Expected: 16 consecutive `rf_we` cycles, `rf_dst` 0..15, `rf_data`=0, `done` on the 16th.
- Op 111, without `REG_CTRL_CLEAR_EN`. Expected: no `rf_we`, `done` at T+2.
